// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard-based hazard unit for an in-order pipeline.
// Tracks per-register result latency and a multi-cycle busy window.
module scoreboard_hazard_unit #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int LW   = 3,
    parameter int CW   = 6,
    parameter int SW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic          id_rs1_use,
    input  logic          id_rs2_use,
    input  logic [AW-1:0] id_rd,
    input  logic          id_we,
    input  logic [LW-1:0] id_lat,
    input  logic          mc_start,
    input  logic [CW-1:0] mc_cycles,
    input  logic          redirect,
    output logic          pc_write,
    output logic          stall_if_id,
    output logic          flush_if_id,
    output logic          flush_id_ex,
    output logic          mc_busy,
    output logic [SW-1:0] stall_count
);

    logic [LW-1:0] pend_q [NREG];
    logic [LW-1:0] pend_d [NREG];
    logic [CW-1:0] busy_q;
    logic [CW-1:0] busy_d;
    logic [SW-1:0] scnt_q;
    logic [SW-1:0] scnt_d;

    logic raw;
    logic waw;
    logic stall;
    logic issue;
    logic rd_nz;

    // Hazard detection from registered scoreboard state only
    always_comb begin
        rd_nz = (id_rd != '0);
        raw   = (id_rs1_use && (pend_q[id_rs1] != '0))
              || (id_rs2_use && (pend_q[id_rs2] != '0));
        waw   = id_we && rd_nz && (pend_q[id_rd] > id_lat);
        stall = id_valid && !redirect
              && (raw || waw || (busy_q != '0));
        issue = id_valid && !redirect && !stall;
    end

    // Pipeline control outputs; redirect wins over stall
    always_comb begin
        pc_write    = !stall;
        stall_if_id = stall;
        flush_id_ex = stall || redirect;
        flush_if_id = redirect;
        mc_busy     = (busy_q != '0);
        stall_count = scnt_q;
    end

    // Next scoreboard: age every entry, then overlay the issuing write
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend_d[r] = (pend_q[r] != '0) ? pend_q[r] - LW'(1) : '0;
        end
        if (issue && id_we && rd_nz) begin
            pend_d[id_rd] = id_lat;
        end
        pend_d[0] = '0;
    end

    // Next busy counter and saturating stall counter
    always_comb begin
        busy_d = busy_q;
        if (issue && mc_start) begin
            busy_d = mc_cycles;
        end else if (busy_q != '0) begin
            busy_d = busy_q - CW'(1);
        end
        scnt_d = scnt_q;
        if (stall && !(&scnt_q)) begin
            scnt_d = scnt_q + SW'(1);
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= '0;
            end
            busy_q <= '0;
            scnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= pend_d[r];
            end
            busy_q <= busy_d;
            scnt_q <= scnt_d;
        end
    end

endmodule

// File: doc/scoreboard_hazard_unit.md
SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers; register 0 is hardwired zero.
REQ-002 Parameter AW, default 5: register-index width, with 2**AW >= NREG.
REQ-003 Parameter LW, default 3: width of the result-latency field; maximum latency is 2**LW-1.
REQ-004 Parameter CW, default 6: width of the multi-cycle busy counter.
REQ-005 Parameter SW, default 16: width of the stall performance counter.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-007 Port clk  in  1: single clock; all state updates on the rising edge.
REQ-008 Port rst  in  1: asynchronous active-high reset.
REQ-009 Port id_valid  in  1: an instruction is present in ID.
REQ-010 Ports id_rs1 / id_rs2  in  AW: ID source register indices.
REQ-011 Ports id_rs1_use / id_rs2_use  in  1: the ID instruction reads that source.
REQ-012 Port id_rd  in  AW: ID destination register index.
REQ-013 Port id_we  in  1: the ID instruction writes id_rd.
REQ-014 Port id_lat  in  LW: cycles after issue until the result is forwardable; 0 = ALU op, 1 = load.
REQ-015 Port mc_start  in  1: the ID instruction is multi-cycle, such as divide.
REQ-016 Port mc_cycles  in  CW: front-end busy cycles for a multi-cycle op.
REQ-017 Port redirect  in  1: branch or jump resolved taken; the fetch path is wrong.
REQ-018 Port pc_write  out  1: the PC may advance.
REQ-019 Port stall_if_id  out  1: hold the IF/ID register.
REQ-020 Port flush_if_id  out  1: clear IF/ID to a NOP.
REQ-021 Port flush_id_ex  out  1: insert a bubble into ID/EX.
REQ-022 Port mc_busy  out  1: the multi-cycle unit is occupied.
REQ-023 Port stall_count  out  SW: count of stall cycles.

Function
REQ-024 State: pend[r] (LW bits) for r=1..NREG-1, plus busy_cnt (CW bits), plus stall_count; pend[0] SHALL always read 0.
REQ-025 raw = (id_rs1_use & pend[id_rs1]!=0) | (id_rs2_use & pend[id_rs2]!=0), using registered state only.
REQ-026 waw = id_we & id_rd!=0 & pend[id_rd] > id_lat, which stalls to keep write order.
REQ-027 stall = id_valid & ~redirect & (raw | waw | busy_cnt!=0).
REQ-028 issue = id_valid & ~redirect & ~stall.
REQ-029 Combinational outputs:
- pc_write = ~stall
- stall_if_id = stall
- flush_id_ex = stall | redirect
- flush_if_id = redirect
- mc_busy = busy_cnt!=0
REQ-030 Redirect has priority over stall: when redirect=1, stall=0, pc_write=1, and both flushes are 1, for exactly the cycles redirect is high.
REQ-031 Each cycle, every nonzero pend[r] SHALL decrement by 1.
REQ-032 On issue with id_we=1 and id_rd!=0, pend[id_rd] loads id_lat; the load overrides a same-cycle decrement of that entry.
REQ-033 A load with id_lat=1 followed by a dependent instruction SHALL produce exactly one bubble.
REQ-034 A load with id_lat=N SHALL produce N bubbles on a dependent instruction.
REQ-035 id_rd=0 or id_we=0 SHALL never modify pend.
REQ-036 On issue with mc_start=1, busy_cnt loads mc_cycles; mc_cycles=0 SHALL cause no busy.
REQ-037 When busy_cnt is nonzero and no load occurs, busy_cnt decrements by 1; mc_start is ignored unless issue=1.
REQ-038 stall_count increments by 1 on each cycle with stall=1 and saturates at 2**SW-1 without wrapping.
REQ-039 Redirect SHALL NOT clear pend or busy_cnt; in-flight older instructions still complete.

Reset
REQ-040 While rst=1, asynchronously: all pend=0, busy_cnt=0, stall_count=0; hence pc_write=1, stall_if_id=0, flush_if_id=0, flush_id_ex=0 (for redirect=0), mc_busy=0.
REQ-041 Reset asserted mid-stall SHALL release the stall in the same cycle, and no pending entry SHALL survive deassertion.

Verification
REQ-042 Load-use: issue load with rd=5, id_lat=1; next cycle, issue id_rs1=5 use=1. Required: one cycle of stall=1 with flush_id_ex=1 and pc_write=0, then issue; stall_count=1.
REQ-043 Long latency: id_lat=3 to rd=7, then a dependent instruction on rs2=7. Required: 3 stall cycles, then issue.
REQ-044 Register zero: id_lat=7 to rd=0, then a dependent instruction on rs1=0. Required: no stall.
REQ-045 Multi-cycle: issue mc_start=1 with mc_cycles=4. Required: mc_busy=1 for 4 cycles, stall on any valid ID instruction during them, then release.
REQ-046 Redirect during a load-use stall. Required: same cycle flush_if_id=1, flush_id_ex=1, pc_write=1, no issue, and pend unchanged.
REQ-047 WAW case: pend[9]=3, then ID writes rd=9 with id_lat=0. Required: stall until pend[9]=0, then issue. Separately, force 2**SW stall cycles: stall_count holds at 2**SW-1.
